// File: rtl/lebug_pkg.sv
//------------------------------------------------------------------------------
// Module   : lebug_pkg
// Brief    : Shared mode encodings for the trace-path data packer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lebug_pkg;
    localparam logic [7:0] MODE_PASS = 8'd0;
    localparam logic [7:0] MODE_PACK = 8'd1;
endpackage

`default_nettype wire

// File: rtl/data_packer_lane.sv
//------------------------------------------------------------------------------
// Module   : pack_lane
// Brief    : Per-chain scalar pack buffer; gathers element-0 scalars into a
//            dense vector and raises emit on the closing push.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pack_lane #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           eof,
    input  logic                           clear,
    output logic                           emit,
    output logic [N-1:0][DATA_WIDTH-1:0]   vec,
    output logic [$clog2(N):0]             fill
);
    localparam int unsigned CW = $clog2(N);

    logic [CW-1:0]                 count;
    logic [N-1:0][DATA_WIDTH-1:0]  buffer;
    logic                          last;

    // Slots above count are always zero because the buffer is wiped on every
    // emit and clear, so the assembled vector only needs the current slot patched.
    always_comb begin
        last        = (count == CW'(N - 1)) || eof;
        emit        = push && last;
        fill        = {1'b0, count} + (CW + 1)'(1);
        vec         = buffer;
        vec[count]  = data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            buffer <= '0;
        end else if (clear) begin
            count  <= '0;
            buffer <= '0;
        end else if (push) begin
            if (last) begin
                count  <= '0;
                buffer <= '0;
            end else begin
                buffer[count] <= data;
                count         <= count + CW'(1);
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/data_packer.sv
//------------------------------------------------------------------------------
// Module   : data_packer
// Brief    : Per-chain pass-through or scalar compaction of reduce-unit vectors
//            ahead of the trace buffer; one-cycle registered output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_packer
    import lebug_pkg::*;
#(
    parameter int unsigned N                  = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MAX_CHAINS         = 4,
    parameter int unsigned PERSONAL_CONFIG_ID = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    input  logic                                eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]       chainId_in,
    input  logic                                tracing,
    input  logic [7:0]                          configId,
    input  logic [7:0]                          configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
    output logic                                valid_out,
    output logic                                eof_out,
    output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
    output logic [$clog2(N):0]                  fill_out,
    output logic [N-1:0][DATA_WIDTH-1:0]        vector_out
);
    localparam int unsigned CHW = $clog2(MAX_CHAINS);
    localparam int unsigned FW  = $clog2(N) + 1;

    logic [7:0]                    mode      [MAX_CHAINS];
    logic                          lane_push [MAX_CHAINS];
    logic                          lane_clr  [MAX_CHAINS];
    logic                          lane_emit [MAX_CHAINS];
    logic [N-1:0][DATA_WIDTH-1:0]  lane_vec  [MAX_CHAINS];
    logic [FW-1:0]                 lane_fill [MAX_CHAINS];

    logic                          accept;
    logic                          cfg_wr;
    logic                          sel_pack;
    logic                          sel_emit;
    logic [N-1:0][DATA_WIDTH-1:0]  sel_vec;
    logic [FW-1:0]                 sel_fill;

    assign accept = tracing && valid_in;
    assign cfg_wr = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));

    generate
        for (genvar k = 0; k < MAX_CHAINS; k++) begin : g_lane
            assign lane_push[k] = accept && (chainId_in == CHW'(k)) && (mode[k] == MODE_PACK);
            assign lane_clr[k]  = cfg_wr && (chainId_in == CHW'(k));

            pack_lane #(
                .N          (N),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (lane_push[k]),
                .data  (vector_in[0]),
                .eof   (eof_in),
                .clear (lane_clr[k]),
                .emit  (lane_emit[k]),
                .vec   (lane_vec[k]),
                .fill  (lane_fill[k])
            );
        end
    endgenerate

    // An out-of-range chain id selects nothing and so falls back to pass-through.
    always_comb begin
        sel_pack = 1'b0;
        sel_emit = 1'b0;
        sel_vec  = '0;
        sel_fill = '0;
        for (int k = 0; k < MAX_CHAINS; k++) begin
            if (chainId_in == CHW'(k)) begin
                sel_pack = (mode[k] == MODE_PACK);
                sel_emit = lane_emit[k];
                sel_vec  = lane_vec[k];
                sel_fill = lane_fill[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_CHAINS; k++) begin
                mode[k] <= MODE_PASS;
            end
        end else if (cfg_wr) begin
            for (int k = 0; k < MAX_CHAINS; k++) begin
                if (chainId_in == CHW'(k)) begin
                    mode[k] <= configData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= '0;
            fill_out    <= '0;
            vector_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            if (accept && !sel_pack) begin
                valid_out   <= 1'b1;
                eof_out     <= eof_in;
                chainId_out <= chainId_in;
                fill_out    <= FW'(N);
                vector_out  <= vector_in;
            end else if (sel_emit) begin
                valid_out   <= 1'b1;
                eof_out     <= eof_in;
                chainId_out <= chainId_in;
                fill_out    <= sel_fill;
                vector_out  <= sel_vec;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_data_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_data_packer
// Brief    : Directed self-checking bench for data_packer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_packer;
    typedef logic [7:0][31:0] vec_t;
    typedef logic [263:0]     obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        eof_in;
    logic [1:0]  chainId_in;
    logic        tracing;
    logic [7:0]  configId;
    logic [7:0]  configData;
    vec_t        vector_in;
    logic        valid_out;
    logic        eof_out;
    logic [1:0]  chainId_out;
    logic [3:0]  fill_out;
    vec_t        vector_out;

    int checks = 0;
    int errors = 0;

    obs_t obs;
    assign obs = {valid_out, eof_out, chainId_out, fill_out, vector_out};

    always #5 clk = ~clk;

    data_packer #(
        .N                  (8),
        .DATA_WIDTH         (32),
        .MAX_CHAINS         (4),
        .PERSONAL_CONFIG_ID (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .chainId_out (chainId_out),
        .fill_out    (fill_out),
        .vector_out  (vector_out)
    );

    function automatic vec_t seq(input int start, input int n);
        vec_t v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 32'(start + i);
        return v;
    endfunction

    task automatic apply(input logic v, input logic e, input logic tr, input logic [1:0] ch,
                         input vec_t vec, input logic [7:0] cid, input logic [7:0] cd);
        valid_in = v; eof_in = e; tracing = tr; chainId_in = ch;
        vector_in = vec; configId = cid; configData = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic push_scalar(input logic [1:0] ch, input logic e, input int s);
        vec_t v;
        v    = {8{32'd99}};
        v[0] = 32'(s);
        apply(1'b1, e, 1'b1, ch, v, 8'd0, 8'd0);
    endtask

    task automatic do_config(input logic [1:0] ch, input logic [7:0] m);
        apply(1'b0, 1'b0, 1'b0, ch, '0, 8'd1, m);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass;
        obs_t exp;
        apply(1'b1, 1'b1, 1'b1, 2'd0, seq(1, 8), 8'd0, 8'd0);
        exp = {1'b1, 1'b1, 2'd0, 4'd8, seq(1, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pass_out: got %h expected %h", obs, exp);
        end
        apply(1'b0, 1'b0, 1'b1, 2'd0, seq(50, 8), 8'd0, 8'd0);
        exp = {1'b0, 1'b1, 2'd0, 4'd8, seq(1, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pass_hold: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_pack_full;
        obs_t exp;
        do_config(2'd1, 8'd1);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL config_valid: got %b expected 0", valid_out);
        end
        for (int i = 0; i < 8; i++) begin
            push_scalar(2'd1, 1'b0, 10 + i);
            if (i < 7) begin
                checks++;
                if (valid_out !== 1'b0) begin
                    errors++; $display("FAIL pack_full_wait%0d: got %b expected 0", i, valid_out);
                end
            end
        end
        exp = {1'b1, 1'b0, 2'd1, 4'd8, seq(10, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pack_full_out: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_pack_partial;
        obs_t exp;
        push_scalar(2'd1, 1'b0, 5);
        push_scalar(2'd1, 1'b0, 6);
        push_scalar(2'd1, 1'b1, 7);
        exp = {1'b1, 1'b1, 2'd1, 4'd3, seq(5, 3)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pack_partial_out: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 8; i++) push_scalar(2'd1, 1'b0, 20 + i);
        exp = {1'b1, 1'b0, 2'd1, 4'd8, seq(20, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pack_after_eof: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_interleave;
        obs_t exp;
        do_config(2'd0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            push_scalar(2'd0, 1'b0, 30 + i);
            if (i < 7) begin
                checks++;
                if (valid_out !== 1'b0) begin
                    errors++; $display("FAIL ilv_pack_wait%0d: got %b expected 0", i, valid_out);
                end
            end else begin
                exp = {1'b1, 1'b0, 2'd0, 4'd8, seq(30, 8)};
                checks++;
                if (obs !== exp) begin
                    errors++; $display("FAIL ilv_pack_out: got %h expected %h", obs, exp);
                end
            end
            apply(1'b1, (i == 3), 1'b1, 2'd2, seq(100 + 10 * i, 8), 8'd0, 8'd0);
            exp = {1'b1, (i == 3), 2'd2, 4'd8, seq(100 + 10 * i, 8)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL ilv_pass%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_other_mode;
        obs_t exp;
        do_config(2'd3, 8'd7);
        apply(1'b1, 1'b0, 1'b1, 2'd3, seq(200, 8), 8'd0, 8'd0);
        exp = {1'b1, 1'b0, 2'd3, 4'd8, seq(200, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL other_mode_pass: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_tracing_low;
        obs_t exp;
        for (int i = 0; i < 3; i++) push_scalar(2'd1, 1'b0, 80 + i);
        apply(1'b0, 1'b1, 1'b1, 2'd1, seq(1, 8), 8'd0, 8'd0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL eof_no_valid: got %b expected 0", valid_out);
        end
        apply(1'b1, 1'b1, 1'b0, 2'd1, seq(1, 8), 8'd2, 8'd0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL tracing_low_valid: got %b expected 0", valid_out);
        end
        for (int i = 3; i < 8; i++) push_scalar(2'd1, 1'b0, 80 + i);
        exp = {1'b1, 1'b0, 2'd1, 4'd8, seq(80, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL tracing_low_resume: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_config_mid;
        obs_t exp;
        for (int i = 0; i < 4; i++) push_scalar(2'd1, 1'b0, 60 + i);
        do_config(2'd1, 8'd1);
        for (int i = 0; i < 8; i++) push_scalar(2'd1, 1'b0, 70 + i);
        exp = {1'b1, 1'b0, 2'd1, 4'd8, seq(70, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL config_mid_out: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid;
        obs_t exp;
        for (int i = 0; i < 4; i++) push_scalar(2'd1, 1'b0, 40 + i);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_config(2'd1, 8'd1);
        for (int i = 0; i < 8; i++) push_scalar(2'd1, 1'b0, 50 + i);
        exp = {1'b1, 1'b0, 2'd1, 4'd8, seq(50, 8)};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_mid_out: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        valid_in = 1'b0; eof_in = 1'b0; chainId_in = '0; tracing = 1'b1;
        configId = '0; configData = '0; vector_in = '0; rst_n = 1'b0;
        test_reset;
        test_pass;
        test_pack_full;
        test_pack_partial;
        test_interleave;
        test_other_mode;
        test_tracing_low;
        test_config_mid;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
